// File: rtl/osc_trig_smp_mc.sv
`default_nettype none
// ============================================================================
//  Module   : osc_trig_smp_mc
//  Purpose  : Multi-channel oscilloscope trigger/sampler with a circular
//             pre-trigger buffer, edge/force/timeout triggering and readout.
//             Optional macro OSC_TRIG_HYST_EN adds trigger hysteresis.
//  Revision : 1.0  initial release
// ============================================================================
module osc_trig_smp_mc #(
    parameter int DW  = 8,
    parameter int AW  = 10,
    parameter int NCH = 2,
    parameter int TOW = 27,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH*DW-1:0]     din,
    input  logic                  smp_en,
    input  logic                  start,
    input  logic [CW-1:0]         trig_ch,
    input  logic [1:0]            edge_mode,
    input  logic signed [DW-1:0]  level,
    input  logic [AW-1:0]         hpos,
    input  logic [TOW-1:0]        to,
`ifdef OSC_TRIG_HYST_EN
    input  logic [DW-1:0]         hyst,
`endif
    input  logic                  read,
    output logic [NCH*DW-1:0]     dout,
    output logic                  dout_valid,
    output logic                  busy,
    output logic                  trig_flag
);

    localparam int D = 2**AW;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_ARM  = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]              state;
    logic [2:0]              state_nxt;

    logic [CW-1:0]           cfg_ch;
    logic [1:0]              cfg_mode;
    logic signed [DW-1:0]    cfg_lvl;
    logic [AW-1:0]           cfg_hpos;
    logic [TOW-1:0]          cfg_to;

    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW-1:0]           trig_ptr;
    logic [AW-1:0]           pre_cnt;
    logic [AW:0]             post_cnt;
    logic [TOW-1:0]          tmo_cnt;
    logic signed [DW-1:0]    prev;
    logic                    prev_valid;

    logic [NCH*DW-1:0]       mem [D];

    logic signed [DW-1:0]    ch_smp [NCH];
    logic signed [DW-1:0]    cur;
    logic                    capturing;
    logic                    smp;
    logic                    start_ok;
    logic                    rise_hit;
    logic                    fall_hit;
    logic                    edge_hit;
    logic                    force_hit;
    logic                    tmo_hit;
    logic                    trig_now;
    logic [AW:0]             post_tgt;
    logic                    last_pre;
    logic                    last_post;

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_ch
            assign ch_smp[k] = din[k*DW +: DW];
        end
    endgenerate

    assign cur       = ch_smp[cfg_ch];
    assign capturing = (state == S_PRE) || (state == S_ARM) || (state == S_POST);
    assign smp       = smp_en && capturing;
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
    assign post_tgt  = (AW+1)'(D) - {1'b0, cfg_hpos};
    assign last_pre  = (pre_cnt + AW'(1)) == cfg_hpos;
    assign last_post = (post_cnt + (AW+1)'(1)) == post_tgt;

`ifdef OSC_TRIG_HYST_EN
    logic [DW-1:0]           cfg_hyst;
    logic                    arm_r;
    logic                    arm_f;
    logic [DW+1:0]           lo_w;
    logic [DW+1:0]           hi_w;
    logic signed [DW-1:0]    lo_lim;
    logic signed [DW-1:0]    hi_lim;

    // Two guard bits so that level-hyst never wraps before saturation.
    assign lo_w   = {{2{cfg_lvl[DW-1]}}, cfg_lvl} - {2'b00, cfg_hyst};
    assign hi_w   = {{2{cfg_lvl[DW-1]}}, cfg_lvl} + {2'b00, cfg_hyst};
    assign lo_lim = ((lo_w[DW+1:DW-1] == 3'b000) || (lo_w[DW+1:DW-1] == 3'b111))
                    ? lo_w[DW-1:0] : {1'b1, {(DW-1){1'b0}}};
    assign hi_lim = ((hi_w[DW+1:DW-1] == 3'b000) || (hi_w[DW+1:DW-1] == 3'b111))
                    ? hi_w[DW-1:0] : {1'b0, {(DW-1){1'b1}}};
    assign rise_hit = arm_r && (cur >= cfg_lvl);
    assign fall_hit = arm_f && (cur <  cfg_lvl);

    // A crossing of the level consumes the arm even when it does not fire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_hyst <= '0;
            arm_r    <= 1'b0;
            arm_f    <= 1'b0;
        end else if (start_ok) begin
            cfg_hyst <= hyst;
            arm_r    <= 1'b0;
            arm_f    <= 1'b0;
        end else if (trig_now) begin
            arm_r    <= 1'b0;
            arm_f    <= 1'b0;
        end else if (smp) begin
            if (cur < lo_lim)
                arm_r <= 1'b1;
            else if (cur >= cfg_lvl)
                arm_r <= 1'b0;
            if (cur > hi_lim)
                arm_f <= 1'b1;
            else if (cur < cfg_lvl)
                arm_f <= 1'b0;
        end
    end
`else
    assign rise_hit = prev_valid && (prev <  cfg_lvl) && (cur >= cfg_lvl);
    assign fall_hit = prev_valid && (prev >= cfg_lvl) && (cur <  cfg_lvl);
`endif

    always_comb begin
        edge_hit = 1'b0;
        case (cfg_mode)
            2'b00:   edge_hit = rise_hit;
            2'b01:   edge_hit = fall_hit;
            2'b10:   edge_hit = rise_hit || fall_hit;
            default: edge_hit = 1'b0;
        endcase
    end

    assign force_hit = (cfg_mode == 2'b11);
    assign tmo_hit   = (cfg_to != '0) && (tmo_cnt >= cfg_to);
    assign trig_now  = (state == S_ARM) && smp_en && (edge_hit || force_hit || tmo_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start)
                    state_nxt = (hpos == '0) ? S_ARM : S_PRE;
            end
            S_PRE: begin
                if (smp_en && last_pre)
                    state_nxt = S_ARM;
            end
            S_ARM: begin
                if (trig_now)
                    state_nxt = (post_tgt == (AW+1)'(1)) ? S_DONE : S_POST;
            end
            S_POST: begin
                if (smp_en && last_post)
                    state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = capturing;
    end

    always_ff @(posedge clk) begin
        if (smp)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_ch     <= '0;
            cfg_mode   <= '0;
            cfg_lvl    <= '0;
            cfg_hpos   <= '0;
            cfg_to     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            trig_ptr   <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            tmo_cnt    <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            trig_flag  <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (start_ok) begin
                cfg_ch     <= trig_ch;
                cfg_mode   <= edge_mode;
                cfg_lvl    <= level;
                cfg_hpos   <= hpos;
                cfg_to     <= to;
                wr_ptr     <= '0;
                pre_cnt    <= '0;
                tmo_cnt    <= '0;
                prev_valid <= 1'b0;
                trig_flag  <= 1'b0;
            end else begin
                if (smp) begin
                    wr_ptr     <= wr_ptr + AW'(1);
                    prev       <= cur;
                    prev_valid <= 1'b1;
                end
                if ((state == S_PRE) && smp_en)
                    pre_cnt <= pre_cnt + AW'(1);
                if ((state == S_ARM) && (tmo_cnt != '1))
                    tmo_cnt <= tmo_cnt + TOW'(1);
                if (trig_now) begin
                    trig_ptr  <= wr_ptr;
                    post_cnt  <= (AW+1)'(1);
                    trig_flag <= edge_hit || force_hit;
                    if (post_tgt == (AW+1)'(1))
                        rd_ptr <= wr_ptr - cfg_hpos;
                end
                if ((state == S_POST) && smp_en) begin
                    post_cnt <= post_cnt + (AW+1)'(1);
                    if (last_post)
                        rd_ptr <= trig_ptr - cfg_hpos;
                end
                if ((state == S_DONE) && read) begin
                    dout       <= mem[rd_ptr];
                    dout_valid <= 1'b1;
                    rd_ptr     <= rd_ptr + AW'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_osc_trig_smp_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_osc_trig_smp_mc
//  Purpose  : Directed self-checking bench for osc_trig_smp_mc.
//  Revision : 1.0  initial release
// ============================================================================
module tb_osc_trig_smp_mc;

    localparam int DW  = 8;
    localparam int AW  = 10;
    localparam int NCH = 2;
    localparam int TOW = 27;
    localparam int CW  = 1;
    localparam int D   = 1024;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NCH*DW-1:0]    din = '0;
    logic                 smp_en = 1'b0;
    logic                 start = 1'b0;
    logic [CW-1:0]        trig_ch = '0;
    logic [1:0]           edge_mode = '0;
    logic signed [DW-1:0] level = '0;
    logic [AW-1:0]        hpos = '0;
    logic [TOW-1:0]       to = '0;
    logic [DW-1:0]        hyst = '0;
    logic                 read = 1'b0;
    logic [NCH*DW-1:0]    dout;
    logic                 dout_valid;
    logic                 busy;
    logic                 trig_flag;

    int n_run  = 0;
    int n_fail = 0;
    int sine [256];
    int scen   = 0;
    int got0 [D];
    logic [NCH*DW-1:0] last_exp = '0;

    osc_trig_smp_mc #(.DW(DW), .AW(AW), .NCH(NCH), .TOW(TOW)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .smp_en     (smp_en),
        .start      (start),
        .trig_ch    (trig_ch),
        .edge_mode  (edge_mode),
        .level      (level),
        .hpos       (hpos),
        .to         (to),
`ifdef OSC_TRIG_HYST_EN
        .hyst       (hyst),
`endif
        .read       (read),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .trig_flag  (trig_flag)
    );

    always #5 clk = ~clk;

    // Scenario 0: ch0 sine, ch1 zero. Scenario 1: noise around 0, dip, rise.
    function automatic int samp(int ch, int j);
        if (j < 0) return 0;
        if (scen == 1) begin
            if (ch != 0) return 0;
            if (j < 40)  return (j % 2) ? 10 : -10;
            if (j == 40) return -30;
            return 5;
        end
        return (ch == 0) ? sine[j % 256] : 0;
    endfunction

    function automatic logic [NCH*DW-1:0] pack(int j);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        a = DW'(samp(0, j));
        b = DW'(samp(1, j));
        return {b, a};
    endfunction

    // Sample j is presented at clock edge per*j+1 after the start edge.
    task automatic find_trig(input int ch, input int mode, input int lvl, input int hp,
                             input int tov, input int per, output int tj, output bit fl);
        int tmo_j;
        int kf;
        int c;
        int p;
        bit r;
        bit f;
        bit e;
        tj = -1;
        fl = 1'b0;
        if (tov == 0) begin
            tmo_j = 1 << 30;
        end else begin
            kf    = (hp == 0) ? 1 : per * (hp - 1) + 2;
            tmo_j = (kf + tov - 1 + per - 1) / per;
        end
        for (int j = hp; j < hp + 100000; j++) begin
            c = samp(ch, j);
            p = samp(ch, j - 1);
            r = (j > 0) && (p <  lvl) && (c >= lvl);
            f = (j > 0) && (p >= lvl) && (c <  lvl);
            e = (mode == 0) ? r : (mode == 1) ? f : (mode == 2) ? (r || f) : 1'b0;
            if (mode == 3 || e) begin
                tj = j;
                fl = 1'b1;
                return;
            end
            if (j >= tmo_j) begin
                tj = j;
                fl = 1'b0;
                return;
            end
        end
    endtask

    task automatic do_capture(input string nm, input int ch, input int mode, input int lvl,
                              input int hp, input int tov, input int hy, input int per,
                              input int poke, input int tj, input bit fl, input int nread);
        int  j;
        int  exp_total;
        int  bad;
        int  vcnt;
        bit  done;
        logic [NCH*DW-1:0] e;
        trig_ch   = CW'(ch);
        edge_mode = 2'(mode);
        level     = DW'(lvl);
        hpos      = AW'(hp);
        to        = TOW'(tov);
        hyst      = DW'(hy);
        start     = 1'b1;
        smp_en    = 1'b1;
        din       = 16'h55AA;
        @(posedge clk); #1;
        start  = 1'b0;
        smp_en = 1'b0;
        n_run++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_start: got %b expected 1", nm, busy);
        end
        j = 0;
        done = 1'b0;
        exp_total = tj + D - hp;
        for (int k = 1; k <= 20000 && !done; k++) begin
            smp_en = ((k - 1) % per == 0);
            din    = pack(j);
            if (poke >= 0 && j == poke && smp_en) begin
                start     = 1'b1;
                hpos      = '0;
                edge_mode = 2'b11;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (smp_en) j++;
            if (!busy) done = 1'b1;
        end
        smp_en = 1'b0;
        n_run++;
        if (!done || j != exp_total) begin
            n_fail++;
            $display("FAIL %s sample_count: got %0d (done=%0b) expected %0d", nm, j, done, exp_total);
        end
        n_run++;
        if (trig_flag !== fl) begin
            n_fail++;
            $display("FAIL %s trig_flag: got %b expected %b", nm, trig_flag, fl);
        end
        bad  = 0;
        vcnt = 0;
        read = 1'b1;
        for (int i = 0; i < nread; i++) begin
            @(posedge clk); #1;
            if (i == nread - 1) read = 1'b0;
            e = pack(tj - hp + (i % D));
            last_exp = e;
            if (dout_valid === 1'b1) vcnt++;
            if (i < D) got0[i] = int'($signed(dout[DW-1:0]));
            if (dout !== e || dout_valid !== 1'b1) begin
                if (bad == 0)
                    $display("FAIL %s readout[%0d]: got %h valid %b expected %h", nm, i, dout, dout_valid, e);
                bad++;
            end
        end
        n_run++;
        if (bad != 0) n_fail++;
        n_run++;
        if (vcnt != nread) begin
            n_fail++;
            $display("FAIL %s valid_pulses: got %0d expected %0d", nm, vcnt, nread);
        end
        @(posedge clk); #1;
        n_run++;
        if (dout_valid !== 1'b0 || dout !== last_exp) begin
            n_fail++;
            $display("FAIL %s idle_after_read: got valid %b dout %h expected 0 %h", nm, dout_valid, dout, last_exp);
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        n_run++;
        if (busy !== 1'b0 || trig_flag !== 1'b0 || dout !== '0 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got busy %b flag %b dout %h valid %b expected 0 0 0 0",
                     busy, trig_flag, dout, dout_valid);
        end
        @(negedge clk);
        rst    = 1'b1;
        read   = 1'b1;
        smp_en = 1'b1;
        @(posedge clk); #1;
        read   = 1'b0;
        smp_en = 1'b0;
        n_run++;
        if (dout_valid !== 1'b0 || dout !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_read_ignored: got valid %b dout %h busy %b expected 0 0 0",
                     dout_valid, dout, busy);
        end
    endtask

    task automatic test_rising;
        int tj;
        bit fl;
        scen = 0;
        find_trig(0, 0, 100, 250, 0, 4, tj, fl);
        do_capture("rising", 0, 0, 100, 250, 0, 0, 4, -1, tj, fl, D);
        n_run++;
        if (!(got0[250] >= 100 && got0[249] < 100)) begin
            n_fail++;
            $display("FAIL rising_crossing: got r249=%0d r250=%0d expected <100 and >=100", got0[249], got0[250]);
        end
    endtask

    task automatic test_timeout_ch1;
        int tj;
        bit fl;
        scen = 0;
        find_trig(1, 0, 50, 250, 300, 4, tj, fl);
        n_run++;
        if (tj != 325 || fl != 1'b0) begin
            n_fail++;
            $display("FAIL timeout_model: got %0d/%0b expected 325/0", tj, fl);
        end
        do_capture("timeout_ch1", 1, 0, 50, 250, 300, 0, 4, -1, 325, 1'b0, D);
    endtask

    task automatic test_falling_timeout;
        scen = 0;
        do_capture("falling_to", 0, 1, -128, 750, 300, 0, 4, -1, 825, 1'b0, D);
    endtask

    task automatic test_force_hpos0;
        scen = 0;
        do_capture("force_h0", 0, 3, 0, 0, 0, 0, 4, -1, 0, 1'b1, D + 1);
    endtask

    task automatic test_back_to_back;
        int tj;
        bit fl;
        scen = 0;
        find_trig(0, 0, 0, 100, 0, 2, tj, fl);
        do_capture("start_while_busy", 0, 0, 0, 100, 0, 0, 2, 500, tj, fl, D);
    endtask

    task automatic test_reset_mid;
        logic [NCH*DW-1:0] held;
        held      = last_exp;
        scen      = 0;
        edge_mode = 2'b11;
        hpos      = '0;
        to        = '0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            smp_en = 1'b1;
            read   = (i == 50);
            din    = pack(i);
            @(posedge clk); #1;
            if (i == 50) begin
                n_run++;
                if (dout_valid !== 1'b0 || dout !== held) begin
                    n_fail++;
                    $display("FAIL read_while_busy: got valid %b dout %h expected 0 %h", dout_valid, dout, held);
                end
            end
        end
        smp_en = 1'b0;
        read   = 1'b0;
        rst    = 1'b0;
        #1;
        n_run++;
        if (busy !== 1'b0 || dout !== '0 || trig_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_post: got busy %b dout %h flag %b expected 0 0 0", busy, dout, trig_flag);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        do_capture("after_reset_h1023", 0, 3, 0, 1023, 0, 0, 1, -1, 1023, 1'b1, D);
    endtask

`ifdef OSC_TRIG_HYST_EN
    task automatic test_hyst;
        scen = 1;
        do_capture("hyst", 0, 0, 0, 0, 0, 20, 1, -1, 41, 1'b1, D);
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++)
            sine[i] = $rtoi($floor(127.0 * $sin(2.0 * 3.14159265358979 * i / 256.0) + 0.5));
        test_reset;
        test_rising;
        test_timeout_ch1;
        test_falling_timeout;
        test_force_hpos0;
        test_back_to_back;
        test_reset_mid;
`ifdef OSC_TRIG_HYST_EN
        test_hyst;
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
